scanchain_host: RTL and testbench

SCANCHAIN_HOST -- requirements
Module: scanchain_host

---
 rtl/scanchain_host.sv | 154 +++++++++++++++
 tb/tb_scanchain_host.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scanchain_host.sv
// scanchain_host
// Host-side driver for a serial scan chain. One transaction captures the
// chain's module outputs, shifts SCAN_LENGTH bits out (MSB first) while
// shifting the returned bits in, then pulses latch_enable so the chain
// presents the newly shifted word on its module inputs.
//
// Ports
//   clk, reset       : single clock, synchronous active-high reset
//   i_start          : request a transaction (honoured only while idle)
//   i_wdata          : word shifted into the chain, registered at accept
//   o_rdata          : word captured from the chain, updated only in DONE
//   o_busy, o_done   : transaction in progress / one-cycle completion pulse
//   o_scan_clk, o_scan_data, o_scan_select, o_latch_enable : chain drive
//   i_scan_data      : chain serial return
//   o_state          : debug view of the FSM state
//
// Handshake: i_start is sampled only when o_busy=0; the accept edge loads
// i_wdata. o_busy stays high from the cycle after accept through DONE, and
// o_done pulses for exactly one cycle with o_rdata already valid. Requests
// made while busy are dropped, never queued.
module scanchain_host #(
  parameter int SCAN_LENGTH = 96,
  parameter int CLK_DIV     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [SCAN_LENGTH-1:0] i_wdata,
  output logic [SCAN_LENGTH-1:0] o_rdata,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_scan_clk,
  output logic                   o_scan_data,
  output logic                   o_scan_select,
  output logic                   o_latch_enable,
  input  logic                   i_scan_data,
  output logic [2:0]             o_state
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(SCAN_LENGTH);

  // Phase counter walks 0..2*CLK_DIV-1 inside one scan bit period:
  // the first CLK_DIV values are the low phase, the rest the high phase.
  localparam logic [PW-1:0] PH_LAST     = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HIGH     = PW'(CLK_DIV);
  localparam logic [PW-1:0] PH_LOW_LAST = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(SCAN_LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    LATCH   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic [PW-1:0]          phase, phase_nxt;
  logic [BW-1:0]          bit_cnt, bit_nxt;
  logic [SCAN_LENGTH-1:0] wshift, wshift_nxt;
  logic [SCAN_LENGTH-1:0] staging;

  assign o_state = state;

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    bit_nxt    = bit_cnt;
    wshift_nxt = wshift;
    case (state)
      IDLE: begin
        phase_nxt = '0;
        bit_nxt   = '0;
        if (i_start) begin
          state_nxt  = CAPTURE;
          wshift_nxt = i_wdata;
        end
      end
      CAPTURE: begin
        if (phase == PH_LAST) begin
          phase_nxt = '0;
          state_nxt = SHIFT;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      SHIFT: begin
        if (phase == PH_LAST) begin
          phase_nxt = '0;
          // Next bit moves into the MSB, which feeds o_scan_data.
          wshift_nxt = {wshift[SCAN_LENGTH-2:0], 1'b0};
          if (bit_cnt == BIT_LAST) begin
            bit_nxt   = '0;
            state_nxt = LATCH;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      LATCH: begin
        if (phase == PH_LOW_LAST) begin
          phase_nxt = '0;
          state_nxt = DONE;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so that every
  // chain-facing pin comes straight off a flop yet lines up with the state
  // register in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      phase          <= '0;
      bit_cnt        <= '0;
      wshift         <= '0;
      staging        <= '0;
      o_rdata        <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_scan_clk     <= 1'b0;
      o_scan_data    <= 1'b0;
      o_scan_select  <= 1'b0;
      o_latch_enable <= 1'b0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      bit_cnt <= bit_nxt;
      wshift  <= wshift_nxt;
      // Sample at the end of the low phase, just before the chain shifts.
      // Shifting in at the LSB leaves the first received bit in the MSB.
      if (state == SHIFT && phase == PH_LOW_LAST)
        staging <= {staging[SCAN_LENGTH-2:0], i_scan_data};
      if (state_nxt == DONE)
        o_rdata <= staging;
      o_busy         <= (state_nxt != IDLE);
      o_done         <= (state_nxt == DONE);
      o_scan_clk     <= ((state_nxt == CAPTURE) || (state_nxt == SHIFT)) &&
                        (phase_nxt >= PH_HIGH);
      o_scan_data    <= (state_nxt == SHIFT) && wshift_nxt[SCAN_LENGTH-1];
      o_scan_select  <= (state_nxt == CAPTURE);
      o_latch_enable <= (state_nxt == LATCH);
    end
  end

endmodule

// File: tb/tb_scanchain_host.sv
// tb_scanchain_host
// Three hosts share one clock: idx 0 = defaults (96 bits, CLK_DIV 2),
// idx 1 = 8 bits / CLK_DIV 2, idx 2 = 8 bits / CLK_DIV 1. Each host drives
// a behavioural scan chain (capture on select, shift otherwise, latch on
// latch_enable) whose capture word comes from the bench.
module tb_scanchain_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        rst, start;
  logic [2:0][95:0]  wdata, cap, rdata, latched;
  logic [2:0]        busy, done, sclk, sdat, ssel, lat;
  logic [2:0][2:0]   st;

  int n_checks = 0;
  int n_fail   = 0;
  logic [95:0] exp_q[$];

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int SL = (g == 0) ? 96 : 8;
    localparam int D  = (g == 2) ? 1 : 2;
    logic [SL-1:0] rd;
    logic [SL-1:0] chain = '0;
    logic [SL-1:0] lout  = '0;
    logic b, dn, sc, sd, ss, le;
    logic [2:0] s;

    scanchain_host #(.SCAN_LENGTH(SL), .CLK_DIV(D)) u_dut (
      .clk           (clk),
      .reset         (rst[g]),
      .i_start       (start[g]),
      .i_wdata       (wdata[g][SL-1:0]),
      .o_rdata       (rd),
      .o_busy        (b),
      .o_done        (dn),
      .o_scan_clk    (sc),
      .o_scan_data   (sd),
      .o_scan_select (ss),
      .o_latch_enable(le),
      .i_scan_data   (chain[SL-1]),
      .o_state       (s)
    );

    always @(posedge sc) begin
      if (ss) chain <= cap[g][SL-1:0];
      else    chain <= {chain[SL-2:0], sd};
    end
    always @(posedge le) lout <= chain;

    assign rdata[g]   = 96'(rd);
    assign latched[g] = 96'(lout);
    assign busy[g]    = b;
    assign done[g]    = dn;
    assign sclk[g]    = sc;
    assign sdat[g]    = sd;
    assign ssel[g]    = ss;
    assign lat[g]     = le;
    assign st[g]      = s;
  end

  typedef struct {
    int          idx;
    logic [95:0] wd;
    logic [95:0] cp;
    logic [95:0] exp_rd;
    logic [95:0] exp_latched;
    int          exp_lat;
  } vec_t;

  typedef struct {
    int          lat;
    logic [95:0] rd;
    int          rises;
    int          sel_rises;
    int          le_cycles;
    int          le_pulses;
    int          early;
    int          sdat_bad;
    int          done_quiet;
  } res_t;

  function automatic int sl_of(input int idx);
    return (idx == 0) ? 96 : 8;
  endfunction
  function automatic int d_of(input int idx);
    return (idx == 2) ? 1 : 2;
  endfunction
  function automatic logic [95:0] mask_of(input int idx);
    return (idx == 0) ? {96{1'b1}} : 96'hFF;
  endfunction
  // Reference timing: capture period + SCAN_LENGTH shift periods + latch.
  function automatic int model_latency(input int idx);
    return 1 + d_of(idx) * (2 * sl_of(idx) + 3);
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge of the DONE cycle.
  task automatic run_txn(input int idx, input logic [95:0] wd, input logic [95:0] cp,
                         output res_t r);
    logic [95:0] rd0;
    logic psc, plat;
    r = '{lat: -1, rd: '0, default: 0};
    wdata[idx] = wd;
    cap[idx]   = cp;
    start[idx] = 1'b1;
    rd0  = rdata[idx];
    psc  = sclk[idx];
    plat = lat[idx];
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      start[idx] = 1'b0;
      if (sclk[idx] && !psc) begin
        r.rises++;
        if (ssel[idx]) r.sel_rises++;
      end
      if (lat[idx]) begin
        r.le_cycles++;
        if (!plat) r.le_pulses++;
      end
      if (ssel[idx] && sdat[idx]) r.sdat_bad++;
      if (done[idx]) begin
        r.lat = n;
        r.rd  = rdata[idx];
        r.done_quiet = (!sclk[idx] && !ssel[idx] && !lat[idx] && !sdat[idx] && busy[idx]) ? 1 : 0;
        break;
      end
      if (rdata[idx] !== rd0) r.early++;
      psc  = sclk[idx];
      plat = lat[idx];
    end
  endtask

  task automatic check_txn(input string tag, input int idx, input res_t r,
                           input logic [95:0] exp_latched, input int exp_lat);
    chk({tag, " latency"},       96'(r.lat), 96'(exp_lat));
    chk({tag, " rdata"},         r.rd, exp_q.pop_front());
    chk({tag, " latched"},       latched[idx], exp_latched);
    chk({tag, " scan_clk rises"}, 96'(r.rises), 96'(sl_of(idx) + 1));
    chk({tag, " select rises"},  96'(r.sel_rises), 96'd1);
    chk({tag, " latch cycles"},  96'(r.le_cycles), 96'(d_of(idx)));
    chk({tag, " latch pulses"},  96'(r.le_pulses), 96'd1);
    chk({tag, " rdata early"},   96'(r.early), 96'd0);
    chk({tag, " data in capture"}, 96'(r.sdat_bad), 96'd0);
    chk({tag, " done quiet"},    96'(r.done_quiet), 96'd1);
    @(negedge clk);
    chk({tag, " idle after done"}, {95'd0, busy[idx] | done[idx]}, 96'd0);
  endtask

  vec_t        vecs[6];
  res_t        r;
  logic [95:0] wd, cp;
  int          ndone, busy_cnt, first_done;
  int          dpos[$];

  initial begin
    rst   = '1;
    start = '0;
    wdata = '0;
    cap   = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset busy%0d", i),  {95'd0, busy[i]}, 96'd0);
      chk($sformatf("reset done%0d", i),  {95'd0, done[i]}, 96'd0);
      chk($sformatf("reset chain pins%0d", i),
          {92'd0, sclk[i], sdat[i], ssel[i], lat[i]}, 96'd0);
      chk($sformatf("reset rdata%0d", i), rdata[i], 96'd0);
    end
    rst = '0;
    @(negedge clk);

    // Loopback table on the 8-bit hosts.
    vecs[0] = '{1, 96'h3C, 96'hA5, 96'hA5, 96'h3C, 39};
    vecs[1] = '{1, 96'hFF, 96'h00, 96'h00, 96'hFF, 39};
    vecs[2] = '{1, 96'h01, 96'h80, 96'h80, 96'h01, 39};
    vecs[3] = '{2, 96'h3C, 96'hA5, 96'hA5, 96'h3C, 20};
    vecs[4] = '{2, 96'h5A, 96'hC3, 96'hC3, 96'h5A, 20};
    vecs[5] = '{2, 96'h00, 96'hFF, 96'hFF, 96'h00, 20};
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp_rd);
      run_txn(vecs[i].idx, vecs[i].wd, vecs[i].cp, r);
      check_txn($sformatf("vec%0d", i), vecs[i].idx, r, vecs[i].exp_latched, vecs[i].exp_lat);
    end

    // Random words on the default-size host against the reference model.
    for (int i = 0; i < 3; i++) begin
      wd = {$urandom, $urandom, $urandom};
      cp = {$urandom, $urandom, $urandom} | 96'd1;
      exp_q.push_back(cp);
      run_txn(0, wd, cp, r);
      check_txn($sformatf("rand%0d", i), 0, r, wd, model_latency(0));
    end

    // Reset in SHIFT bit 40 (cycles 165..168 after accept), with start high.
    wdata[0] = {$urandom, $urandom, $urandom};
    cap[0]   = {$urandom, $urandom, $urandom};
    start[0] = 1'b1;
    for (int n = 1; n <= 166; n++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    chk("busy before abort", {95'd0, busy[0]}, 96'd1);
    rst[0]   = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    chk("abort busy/done", {94'd0, busy[0], done[0]}, 96'd0);
    chk("abort chain pins", {92'd0, sclk[0], sdat[0], ssel[0], lat[0]}, 96'd0);
    chk("abort rdata", rdata[0], 96'd0);
    rst[0]   = 1'b0;
    start[0] = 1'b0;
    ndone = 0;
    busy_cnt = 0;
    for (int n = 0; n < 450; n++) begin
      @(negedge clk);
      if (done[0] || lat[0]) ndone++;
      if (busy[0]) busy_cnt++;
    end
    chk("no done/latch after abort", 96'(ndone), 96'd0);
    chk("no busy after abort", 96'(busy_cnt), 96'd0);

    // Pulse while busy is dropped; held start chains back-to-back.
    wdata[1] = 96'h96;
    cap[1]   = 96'h5A;
    start[1] = 1'b1;
    first_done = -1;
    ndone = 0;
    busy_cnt = 0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      start[1] = (n == 10);
      if (done[1]) begin
        ndone++;
        if (first_done < 0) first_done = n;
      end
      if (n >= 40 && busy[1]) busy_cnt++;
    end
    chk("pulse txn done cycle", 96'(first_done), 96'd39);
    chk("pulse txn done count", 96'(ndone), 96'd1);
    chk("pulse not queued", 96'(busy_cnt), 96'd0);
    chk("pulse txn rdata", rdata[1], 96'h5A);

    start[1] = 1'b1;
    for (int m = 1; m <= 130; m++) begin
      @(negedge clk);
      if (done[1]) dpos.push_back(m);
      if (m == 40) chk("held start idle gap", {95'd0, busy[1]}, 96'd0);
      if (m == 41) chk("held start re-accept", {95'd0, busy[1]}, 96'd1);
    end
    start[1] = 1'b0;
    chk("held start done count", 96'(dpos.size()), 96'd3);
    if (dpos.size() == 3) begin
      chk("held done 1", 96'(dpos[0]), 96'd39);
      chk("held done 2", 96'(dpos[1]), 96'd79);
      chk("held done 3", 96'(dpos[2]), 96'd119);
    end
    repeat (50) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
